// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC register and IF/ID pipeline latch.
//   clk               : clock, all state updates on the rising edge
//   rst               : synchronous active-high reset
//   global_stall      : memory-not-ready stall, freezes every register
//   hazard_freeze     : data-hazard stall, holds PC, IF/ID and fetch_count
//   branch_taken      : redirect PC to branch_addr and flush IF/ID
//   branch_addr       : branch target byte address (word-aligned on load)
//   instruction       : instruction-memory read data for pc_out
//   pc_out            : PC register, drives instruction-memory address
//   if_id_pc          : PC + PC_STEP of the instruction held in IF/ID
//   if_id_instruction : instruction word held in IF/ID
//   if_id_valid       : IF/ID holds a real, unflushed instruction
//   fetch_count       : number of instructions accepted into IF/ID
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        global_stall,
  input  logic        hazard_freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;
  logic            if_valid_q;
  logic [XLEN-1:0] count_q;

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] if_pc_d;
  logic [XLEN-1:0] if_instr_d;
  logic            if_valid_d;
  logic [XLEN-1:0] count_d;
  logic [XLEN-1:0] pc_seq;

  // Sequential PC; 32-bit modulo arithmetic wraps silently
  assign pc_seq = XLEN'(pc_q + PC_STEP);

  // Next-state selection: global_stall > branch_taken > hazard_freeze > advance
  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    count_d    = count_q;
    if (global_stall) begin
      // hold everything, including a branch the environment keeps asserted
    end else if (branch_taken) begin
      pc_d       = {branch_addr[XLEN-1:2], 2'b00};
      if_pc_d    = '0;
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end else if (hazard_freeze) begin
      // hold PC, IF/ID and count
    end else begin
      pc_d       = pc_seq;
      if_pc_d    = pc_seq;
      if_instr_d = instruction;
      if_valid_d = 1'b1;
      count_d    = XLEN'(count_q + XLEN'(1));
    end
  end

  // State registers with synchronous reset overriding all other controls
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      count_q    <= count_d;
    end
  end

  assign pc_out            = pc_q;
  assign if_id_pc          = if_pc_q;
  assign if_id_instruction = if_instr_q;
  assign if_id_valid       = if_valid_q;
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. Stimulus pushes the
// expected post-edge state per cycle; a monitor pops and compares after
// each rising edge. Memory model: word 0 at address 0x24, else
// {16'hC0DE, addr[15:0]}.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        global_stall = 1'b0;
  logic        hazard_freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;
  exp_t exp_q[$];

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .global_stall(global_stall),
    .hazard_freeze(hazard_freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .instruction(instruction),
    .pc_out(pc_out),
    .if_id_pc(if_id_pc),
    .if_id_instruction(if_id_instruction),
    .if_id_valid(if_id_valid),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (pc_out == 32'h24) instruction = 32'd0;
    else                  instruction = {16'hC0DE, pc_out[15:0]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL edge %0d %s: got %h expected %h", edge_no, name, act, exp);
    end
  endtask

  // Monitor: compare DUT state after each edge against the scoreboard head
  always @(posedge clk) begin
    exp_t e;
    #1;
    edge_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc_out", pc_out, e.pc);
      check("if_id_pc", if_id_pc, e.ifpc);
      check("if_id_instruction", if_id_instruction, e.instr);
      check("if_id_valid", 32'(if_id_valid), 32'(e.valid));
      check("fetch_count", fetch_count, e.cnt);
    end
  end

  task automatic cyc(input logic r, input logic gs, input logic bt, input logic hf,
                     input logic [31:0] ba, input logic [31:0] epc,
                     input logic [31:0] eifpc, input logic [31:0] einstr,
                     input logic ev, input logic [31:0] ecnt);
    exp_t e;
    @(negedge clk);
    rst = r;
    global_stall = gs;
    branch_taken = bt;
    hazard_freeze = hf;
    branch_addr = ba;
    e.pc = epc;
    e.ifpc = eifpc;
    e.instr = einstr;
    e.valid = ev;
    e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  initial begin
    int wait_cycles;
    // reset wins over stall/branch/freeze
    cyc(1, 1, 1, 1, 32'h55, 32'h0,  32'h0,  32'h0,        0, 0);
    // free-running fetch from RESET_PC
    cyc(0, 0, 0, 0, 32'h0,  32'h4,  32'h4,  32'hC0DE0000, 1, 1);
    cyc(0, 0, 0, 0, 32'h0,  32'h8,  32'h8,  32'hC0DE0004, 1, 2);
    cyc(0, 0, 0, 0, 32'h0,  32'hC,  32'hC,  32'hC0DE0008, 1, 3);
    cyc(0, 0, 0, 0, 32'h0,  32'h10, 32'h10, 32'hC0DE000C, 1, 4);
    cyc(0, 0, 0, 0, 32'h0,  32'h14, 32'h14, 32'hC0DE0010, 1, 5);
    // branch at pc 0x14 to 0x93 -> aligned 0x90, flush
    cyc(0, 0, 1, 0, 32'h93, 32'h90, 32'h0,  32'h0,        0, 5);
    cyc(0, 0, 0, 0, 32'h0,  32'h94, 32'h94, 32'hC0DE0090, 1, 6);
    // reset during branch + freeze
    cyc(1, 0, 1, 1, 32'h40, 32'h0,  32'h0,  32'h0,        0, 0);
    cyc(0, 0, 0, 0, 32'h0,  32'h4,  32'h4,  32'hC0DE0000, 1, 1);
    cyc(0, 0, 0, 0, 32'h0,  32'h8,  32'h8,  32'hC0DE0004, 1, 2);
    // hazard freeze for 3 cycles at pc 8
    cyc(0, 0, 0, 1, 32'h0,  32'h8,  32'h8,  32'hC0DE0004, 1, 2);
    cyc(0, 0, 0, 1, 32'h0,  32'h8,  32'h8,  32'hC0DE0004, 1, 2);
    cyc(0, 0, 0, 1, 32'h0,  32'h8,  32'h8,  32'hC0DE0004, 1, 2);
    cyc(0, 0, 0, 0, 32'h0,  32'hC,  32'hC,  32'hC0DE0008, 1, 3);
    // stall + branch for 2 cycles, branch lands on first unstalled edge
    cyc(0, 1, 1, 0, 32'h23, 32'hC,  32'hC,  32'hC0DE0008, 1, 3);
    cyc(0, 1, 1, 1, 32'h23, 32'hC,  32'hC,  32'hC0DE0008, 1, 3);
    cyc(0, 0, 1, 0, 32'h23, 32'h20, 32'h0,  32'h0,        0, 3);
    cyc(0, 0, 0, 0, 32'h0,  32'h24, 32'h24, 32'hC0DE0020, 1, 4);
    // zero word at 0x24 is still a valid instruction
    cyc(0, 0, 0, 0, 32'h0,  32'h28, 32'h28, 32'h0,        1, 5);
    // branch to top of address space (beats hazard_freeze), then wrap
    cyc(0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 5);
    cyc(0, 0, 0, 0, 32'h0,  32'h0,  32'h0,  32'hC0DEFFFC, 1, 6);
    cyc(0, 0, 0, 0, 32'h0,  32'h4,  32'h4,  32'hC0DE0000, 1, 7);
    // reset during global stall
    cyc(1, 1, 0, 0, 32'h0,  32'h0,  32'h0,  32'h0,        0, 0);
    cyc(0, 0, 0, 0, 32'h0,  32'h4,  32'h4,  32'hC0DE0000, 1, 1);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
